// File: rtl/bp_fe_queue_ckpt_pkg.sv
// rtl/bp_fe_queue_ckpt_pkg.sv - shared FE queue width and per-cycle operation bundle
package bp_fe_queue_ckpt_pkg;

    // Width of one FE queue packet as carried between the front end and back end.
    localparam int fe_queue_width_lp = 32;

    // Effective operations for one cycle, after the same-cycle priority rules are applied.
    typedef struct packed {
        logic clr;
        logic roll;
        logic enq;
        logic yumi;
        logic deq;
    } fe_queue_ops_s;

endpackage

// File: rtl/bp_fe_queue_ckpt_ptr.sv
// rtl/bp_fe_queue_ckpt_ptr.sv - wrap-bit pointer register with clear, load and increment
module bp_fe_queue_ckpt_ptr #(
    parameter int ptr_width_p = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   clr_i,
    input  logic                   load_i,
    input  logic [ptr_width_p-1:0] load_ptr_i,
    input  logic                   inc_i,
    output logic [ptr_width_p-1:0] ptr_o,
    output logic [ptr_width_p-1:0] ptr_next_o
);

    // Next pointer: clear beats load beats increment; the MSB wraps naturally.
    always_comb begin
        ptr_next_o = ptr_o;
        if (clr_i) begin
            ptr_next_o = '0;
        end else if (load_i) begin
            ptr_next_o = load_ptr_i;
        end else if (inc_i) begin
            ptr_next_o = ptr_o + ptr_width_p'(1);
        end
    end

    // Pointer register, cleared asynchronously.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ptr_o <= '0;
        end else begin
            ptr_o <= ptr_next_o;
        end
    end

endmodule

// File: rtl/bp_fe_queue_ckpt.sv
// rtl/bp_fe_queue_ckpt.sv - checkpointing FE-to-BE queue with speculative read, commit and roll
module bp_fe_queue_ckpt
    import bp_fe_queue_ckpt_pkg::*;
#(
    parameter int width_p = fe_queue_width_lp,
    parameter int els_p   = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] fe_queue_i,
    input  logic               fe_queue_v_i,
    output logic               fe_queue_ready_o,
    output logic [width_p-1:0] fe_queue_o,
    output logic               fe_queue_v_o,
    input  logic               fe_queue_yumi_i,
    input  logic               fe_queue_deq_i,
    input  logic               fe_queue_roll_i,
    input  logic               fe_queue_clr_i
);

    localparam int idx_width_lp = $clog2(els_p);
    localparam int ptr_width_lp = idx_width_lp + 1;

    if (els_p < 2 || (els_p & (els_p - 1)) != 0) begin : g_els_check
        $error("bp_fe_queue_ckpt: els_p must be a power of two and at least 2");
    end

    logic [ptr_width_lp-1:0] wptr, rptr, cptr;
    logic [ptr_width_lp-1:0] wptr_next, rptr_next, cptr_next;
    logic                    full;
    logic                    ready_en_r;
    fe_queue_ops_s           ops;

    logic [width_p-1:0] mem [els_p];

    // Full when write and commit pointers share an index but sit on opposite wraps.
    assign full = (wptr[idx_width_lp-1:0] == cptr[idx_width_lp-1:0])
               && (wptr[ptr_width_lp-1] != cptr[ptr_width_lp-1]);

    // Outputs come from registered state only; data is read through the read pointer.
    assign fe_queue_ready_o = ready_en_r & ~full;
    assign fe_queue_v_o     = (rptr != wptr);
    assign fe_queue_o       = mem[rptr[idx_width_lp-1:0]];

    // Resolve same-cycle priority: clr drops everything, roll drops yumi.
    always_comb begin
        ops      = '0;
        ops.clr  = fe_queue_clr_i;
        ops.roll = fe_queue_roll_i & ~fe_queue_clr_i;
        ops.enq  = fe_queue_v_i & fe_queue_ready_o & ~fe_queue_clr_i;
        ops.yumi = fe_queue_yumi_i & fe_queue_v_o & ~fe_queue_clr_i & ~fe_queue_roll_i;
        ops.deq  = fe_queue_deq_i & (cptr != rptr) & ~fe_queue_clr_i;
    end

    // Ready is held low through reset and comes up on the first edge afterwards.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ready_en_r <= 1'b0;
        end else begin
            ready_en_r <= 1'b1;
        end
    end

    bp_fe_queue_ckpt_ptr #(.ptr_width_p(ptr_width_lp)) u_wptr (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .clr_i      (ops.clr),
        .load_i     (1'b0),
        .load_ptr_i ('0),
        .inc_i      (ops.enq),
        .ptr_o      (wptr),
        .ptr_next_o (wptr_next)
    );

    // Roll rewinds the read pointer to where the commit pointer lands this cycle.
    bp_fe_queue_ckpt_ptr #(.ptr_width_p(ptr_width_lp)) u_rptr (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .clr_i      (ops.clr),
        .load_i     (ops.roll),
        .load_ptr_i (cptr_next),
        .inc_i      (ops.yumi),
        .ptr_o      (rptr),
        .ptr_next_o (rptr_next)
    );

    bp_fe_queue_ckpt_ptr #(.ptr_width_p(ptr_width_lp)) u_cptr (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .clr_i      (ops.clr),
        .load_i     (1'b0),
        .load_ptr_i ('0),
        .inc_i      (ops.deq),
        .ptr_o      (cptr),
        .ptr_next_o (cptr_next)
    );

    // Storage write; contents are never reset, unwritten entries are don't-care.
    always_ff @(posedge clk_i) begin
        if (ops.enq) begin
            mem[wptr[idx_width_lp-1:0]] <= fe_queue_i;
        end
    end

    illegal_deq: assert property (@(posedge clk_i) disable iff (reset_i)
        (fe_queue_deq_i & ~fe_queue_clr_i) |-> (cptr != rptr));

    illegal_yumi: assert property (@(posedge clk_i) disable iff (reset_i)
        (fe_queue_yumi_i & ~fe_queue_clr_i & ~fe_queue_roll_i) |-> fe_queue_v_o);

    logic unused_next;
    assign unused_next = ^{wptr_next, rptr_next};

endmodule

// File: tb/tb_bp_fe_queue_ckpt.sv
// tb/tb_bp_fe_queue_ckpt.sv - scoreboard bench for the checkpointing FE queue
module tb_bp_fe_queue_ckpt;
    import bp_fe_queue_ckpt_pkg::*;

    localparam int W   = fe_queue_width_lp;
    localparam int ELS = 8;

    logic         clk = 1'b0;
    logic         reset_i;
    logic [W-1:0] fe_queue_i;
    logic         fe_queue_v_i;
    logic         fe_queue_ready_o;
    logic [W-1:0] fe_queue_o;
    logic         fe_queue_v_o;
    logic         fe_queue_yumi_i;
    logic         fe_queue_deq_i;
    logic         fe_queue_roll_i;
    logic         fe_queue_clr_i;

    always #5 clk = ~clk;

    bp_fe_queue_ckpt #(.width_p(W), .els_p(ELS)) dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .fe_queue_i       (fe_queue_i),
        .fe_queue_v_i     (fe_queue_v_i),
        .fe_queue_ready_o (fe_queue_ready_o),
        .fe_queue_o       (fe_queue_o),
        .fe_queue_v_o     (fe_queue_v_o),
        .fe_queue_yumi_i  (fe_queue_yumi_i),
        .fe_queue_deq_i   (fe_queue_deq_i),
        .fe_queue_roll_i  (fe_queue_roll_i),
        .fe_queue_clr_i   (fe_queue_clr_i)
    );

    typedef struct packed {
        logic         v;
        logic         ready;
        logic [W-1:0] data;
    } exp_t;

    exp_t         scb[$];
    logic [W-1:0] mq[$];
    logic [W-1:0] consumed[$];
    int           rd = 0;
    logic         m_ready_en = 1'b0;
    int           n_checks = 0;
    int           n_fail = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic void push_exp();
        exp_t e;
        e.v     = (rd < mq.size());
        e.ready = m_ready_en && (mq.size() < ELS);
        e.data  = e.v ? mq[rd] : '0;
        scb.push_back(e);
    endfunction

    task automatic idle_inputs();
        fe_queue_i      = '0;
        fe_queue_v_i    = 1'b0;
        fe_queue_yumi_i = 1'b0;
        fe_queue_deq_i  = 1'b0;
        fe_queue_roll_i = 1'b0;
        fe_queue_clr_i  = 1'b0;
    endtask

    task automatic step(input logic v, input logic [W-1:0] d, input logic y,
                        input logic de, input logic ro, input logic cl);
        logic yy, dd, enq;
        yy = y && (rd < mq.size());
        dd = de && (rd > 0);
        fe_queue_v_i    = v;
        fe_queue_i      = d;
        fe_queue_yumi_i = yy;
        fe_queue_deq_i  = dd;
        fe_queue_roll_i = ro;
        fe_queue_clr_i  = cl;
        if (yy && !ro && !cl) consumed.push_back(fe_queue_o);
        enq = v && m_ready_en && (mq.size() < ELS);
        if (cl) begin
            mq.delete();
            rd = 0;
        end else begin
            if (dd) begin
                void'(mq.pop_front());
                rd--;
            end
            if (enq) mq.push_back(d);
            if (ro) rd = 0;
            else if (yy) rd++;
        end
        m_ready_en = 1'b1;
        @(posedge clk);
        #1;
        push_exp();
    endtask

    task automatic do_reset_mid();
        @(negedge clk);
        #1;
        reset_i = 1'b1;
        #1;
        check("async_reset_v", W'(fe_queue_v_o), '0);
        check("async_reset_ready", W'(fe_queue_ready_o), '0);
        mq.delete();
        rd = 0;
        m_ready_en = 1'b0;
        idle_inputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_i = 1'b0;
    endtask

    // Monitor: one expectation per cycle, compared away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (scb.size() > 0) begin
            e = scb.pop_front();
            check("v_o", W'(fe_queue_v_o), W'(e.v));
            check("ready_o", W'(fe_queue_ready_o), W'(e.ready));
            if (e.v) check("data_o", fe_queue_o, e.data);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        idle_inputs();
        reset_i = 1'b1;
        #1;
        check("reset_v", W'(fe_queue_v_o), '0);
        check("reset_ready", W'(fe_queue_ready_o), '0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_i = 1'b0;

        // Reset and single entry
        step(0, 0, 0, 0, 0, 0);
        step(1, 32'hA5, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Fill and full, deq while full does not admit the same-cycle enqueue
        step(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < ELS; i++) step(1, 32'h10 + i, 0, 0, 0, 0);
        step(1, 32'h99, 0, 0, 0, 0);
        for (int i = 0; i < ELS; i++) step(0, 0, 1, 0, 0, 0);
        step(1, 32'h77, 0, 1, 0, 0);
        step(1, 32'h78, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);

        // Roll, then roll with same-cycle deq
        step(0, 0, 0, 0, 0, 1);
        for (int i = 1; i <= 5; i++) step(1, W'(i), 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 2; i++) step(0, 0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 1, 0);
        consumed.delete();
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0);
        check("roll_reread_cnt", W'(consumed.size()), 3);
        for (int j = 0; j < consumed.size() && j < 3; j++) check("roll_reread", consumed[j], W'(j + 3));
        step(0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0);

        // Clr priority on a half-full queue
        step(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(1, 32'h40 + i, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(1, 32'hEE, 1, 1, 0, 1);
        step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < ELS; i++) step(1, 32'h50 + i, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);

        // Streaming with wrap
        consumed.delete();
        for (int i = 0; i < 40; i++) step(1, W'(i), 1, 1, 0, 0);
        guard = 0;
        while (consumed.size() < 40 && guard < 20) begin
            step(0, 0, 1, 1, 0, 0);
            guard++;
        end
        check("stream_count", W'(consumed.size()), 40);
        for (int j = 0; j < consumed.size() && j < 40; j++) check("stream_data", consumed[j], W'(j));

        // Async reset mid-stream with three entries held
        step(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 32'h60 + i, 0, 0, 0, 0);
        do_reset_mid();
        step(0, 0, 0, 0, 0, 0);
        step(1, 32'h5C, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);

        // Randomized traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 59) == 0);
        end
        step(0, 0, 0, 0, 0, 0);

        @(negedge clk);
        #1;
        check("scb_drained", W'(scb.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
